// File: rtl/framebuf_pkg.sv
// framebuf_pkg: FSM state and scan-order encodings shared by framebuf_param and its tests.
package framebuf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_REQ  = 3'd1,
        R_WR   = 3'd2,
        R_REL  = 3'd3,
        S_WAIT = 3'd4,
        S_RD   = 3'd5,
        S_ACK  = 3'd6,
        S_REL  = 3'd7
    } state_t;

    localparam logic [1:0] SCAN_RASTER = 2'd0;
    localparam logic [1:0] SCAN_HMIR   = 2'd1;
    localparam logic [1:0] SCAN_VMIR   = 2'd2;
    localparam logic [1:0] SCAN_ROT180 = 2'd3;

    function automatic logic mirrors_x(input logic [1:0] mode);
        return mode == SCAN_HMIR || mode == SCAN_ROT180;
    endfunction

    function automatic logic mirrors_y(input logic [1:0] mode);
        return mode == SCAN_VMIR || mode == SCAN_ROT180;
    endfunction

endpackage

// File: rtl/framebuf_ram.sv
// framebuf_ram: single-port frame store; synchronous read whose output register holds between reads.
module framebuf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/framebuf_param.sv
// framebuf_param: one-frame buffer, 4-phase receive, replay in raster/H-mirror/V-mirror/rot180 order.
// Define FRAMEBUF_CKSUM_EN to add the per-frame 16-bit channel checksum output cksum.
module framebuf_param
    import framebuf_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int CH    = 3,
    parameter int PW    = 8,
    localparam int AW   = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH*PW-1:0] pixel_in,
    output logic             recev_req,
    input  logic             recev_ack,
    output logic [CH*PW-1:0] pixel_out,
    input  logic             send_req,
    output logic             send_ack,
    input  logic [1:0]       scan_mode,
    output logic             frame_done,
    output logic [AW-1:0]    address,
    output logic [2:0]       state_out
`ifdef FRAMEBUF_CKSUM_EN
    ,
    output logic [15:0]      cksum
`endif
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [AW-1:0] XMAX = AW'(IMG_W - 1);
    localparam logic [AW-1:0] YMAX = AW'(IMG_H - 1);

    state_t        state;
    logic [AW-1:0] rx, x, y, xa, ya, raddr;
    logic [1:0]    mode;
    logic          send_ph, last_px;

    always_comb begin
        xa    = mirrors_x(mode) ? XMAX - x : x;
        ya    = mirrors_y(mode) ? YMAX - y : y;
        raddr = ya * AW'(IMG_W) + xa;
    end

    assign send_ph   = state inside {S_WAIT, S_RD, S_ACK, S_REL};
    assign last_px   = x == XMAX && y == YMAX;
    assign address   = send_ph ? raddr : rx;
    assign state_out = state;

    // The RAM read register doubles as pixel_out: it only reloads in S_RD, so it holds between pixels.
    framebuf_ram #(
        .DEPTH(N),
        .WIDTH(CH * PW),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (state == R_WR && !reset),
        .re   (state == S_RD),
        .addr (address),
        .wdata(pixel_in),
        .rdata(pixel_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx         <= '0;
            x          <= '0;
            y          <= '0;
            mode       <= SCAN_RASTER;
            recev_req  <= 1'b0;
            send_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= R_REQ;
                    recev_req <= 1'b1;
                end
                R_REQ: if (recev_ack) begin
                    state     <= R_WR;
                    recev_req <= 1'b0;
                end
                R_WR: state <= R_REL;
                R_REL: if (!recev_ack) begin
                    if (rx == LAST) begin
                        state <= S_WAIT;
                        mode  <= scan_mode;
                        x     <= '0;
                        y     <= '0;
                    end else begin
                        rx        <= rx + 1'b1;
                        state     <= R_REQ;
                        recev_req <= 1'b1;
                    end
                end
                S_WAIT: if (send_req) state <= S_RD;
                S_RD: begin
                    state    <= S_ACK;
                    send_ack <= 1'b1;
                end
                S_ACK: if (!send_req) begin
                    state    <= S_REL;
                    send_ack <= 1'b0;
                end
                S_REL: begin
                    x <= x == XMAX ? '0 : x + 1'b1;
                    y <= x == XMAX ? y + 1'b1 : y;
                    if (last_px) begin
                        frame_done <= 1'b1;
                        rx         <= '0;
                        recev_req  <= 1'b1;
                        state      <= R_REQ;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAMEBUF_CKSUM_EN
    logic [15:0] px_sum;

    always_comb begin
        px_sum = '0;
        for (int i = 0; i < CH; i++) px_sum = px_sum + 16'(pixel_in[i*PW +: PW]);
    end

    // Restarting on the first write (not on R_REQ) keeps the finished sum visible past frame_done.
    always_ff @(posedge clk) begin
        if (reset) cksum <= '0;
        else if (state == R_WR) cksum <= (rx == '0 ? 16'd0 : cksum) + px_sum;
    end
`endif

endmodule

// File: tb/tb_framebuf_param.sv
// tb_framebuf_param: randomized 4x2 frames through framebuf_param against a scan-order reference model.
module tb_framebuf_param;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pixel_in;
    logic        recev_req, recev_ack;
    logic [23:0] pixel_out;
    logic        send_req, send_ack;
    logic [1:0]  scan_mode;
    logic        frame_done;
    logic [2:0]  address, state_out;
`ifdef FRAMEBUF_CKSUM_EN
    logic [15:0] cksum, fd_ck;
`endif

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    logic [23:0] img [N];

    framebuf_param #(.IMG_W(W), .IMG_H(H), .CH(3), .PW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .recev_req (recev_req),
        .recev_ack (recev_ack),
        .pixel_out (pixel_out),
        .send_req  (send_req),
        .send_ack  (send_ack),
        .scan_mode (scan_mode),
        .frame_done(frame_done),
        .address   (address),
        .state_out (state_out)
`ifdef FRAMEBUF_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
`ifdef FRAMEBUF_CKSUM_EN
            fd_ck = cksum;
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scan-order reference: k-th output pixel comes from the mirrored (x,y) of raster position k.
    function automatic int src_index(input int mode, input int k);
        int px, py;
        px = k % W;
        py = k / W;
        if (mode == 1 || mode == 3) px = W - 1 - px;
        if (mode == 2 || mode == 3) py = H - 1 - py;
        return py * W + px;
    endfunction

    task automatic recv_frame(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (recev_req !== 1'b1 && t < 100) begin tick(); t++; end
            checks++;
            if (recev_req !== 1'b1) begin
                errors++;
                $display("FAIL recv_req_timeout pixel %0d: recev_req=%b required 1", k, recev_req);
                return;
            end
            checks++;
            if (address !== 3'(k)) begin
                errors++;
                $display("FAIL recv_address pixel %0d: got %0d required %0d", k, address, k);
            end
            pixel_in  = img[k];
            recev_ack = 1'b1;
            tick();
            for (int h = 0; h < hold; h++) begin
                checks++;
                if (recev_req !== 1'b0) begin
                    errors++;
                    $display("FAIL recv_req_during_ack pixel %0d: recev_req=%b required 0", k, recev_req);
                end
                tick();
            end
            recev_ack = 1'b0;
            tick();
        end
    endtask

    task automatic send_frame(input int mode, input int hold, input int change_at, input logic [1:0] change_to);
        int fd0, ea, t;
        fd0 = fd_cnt;
        for (int k = 0; k < N; k++) begin
            ea = src_index(mode, k);
            send_req = 1'b1;
            t = 0;
            while (send_ack !== 1'b1 && t < 100) begin tick(); t++; end
            checks++;
            if (send_ack !== 1'b1) begin
                errors++;
                $display("FAIL send_ack_timeout pixel %0d: send_ack=%b required 1", k, send_ack);
                send_req = 1'b0;
                return;
            end
            checks++;
            if (pixel_out !== img[ea]) begin
                errors++;
                $display("FAIL pixel mode %0d out %0d: got %h required %h", mode, k, pixel_out, img[ea]);
            end
            checks++;
            if (address !== 3'(ea)) begin
                errors++;
                $display("FAIL send_address mode %0d out %0d: got %0d required %0d", mode, k, address, ea);
            end
            for (int h = 0; h < hold; h++) begin
                tick();
                checks++;
                if (send_ack !== 1'b1 || pixel_out !== img[ea]) begin
                    errors++;
                    $display("FAIL send_hold out %0d: ack=%b pixel=%h required ack=1 pixel=%h", k, send_ack, pixel_out, img[ea]);
                end
            end
            send_req = 1'b0;
            t = 0;
            while (send_ack !== 1'b0 && t < 100) begin tick(); t++; end
            checks++;
            if (send_ack !== 1'b0 || pixel_out !== img[ea]) begin
                errors++;
                $display("FAIL send_release out %0d: ack=%b pixel=%h required ack=0 pixel=%h", k, send_ack, pixel_out, img[ea]);
            end
            if (k == change_at) scan_mode = change_to;
            if (k < N - 1) begin
                checks++;
                if (fd_cnt != fd0) begin
                    errors++;
                    $display("FAIL early_frame_done out %0d: pulses=%0d required 0", k, fd_cnt - fd0);
                end
            end
        end
        repeat (3) tick();
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d required 1", fd_cnt - fd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({pixel_out, recev_req, send_ack, frame_done, address, state_out} !== '0) begin
            errors++;
            $display("FAIL %s: pixel=%h req=%b ack=%b done=%b addr=%0d state=%0d required all 0",
                     tag, pixel_out, recev_req, send_ack, frame_done, address, state_out);
        end
    endtask

    task automatic plan_frame;
        for (int i = 0; i < N; i++) img[i] = {8'(i + 32), 8'(i + 16), 8'(i)};
    endtask

    task automatic random_frame;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
    endtask

    task automatic test_reset;
        reset = 1'b1; pixel_in = '0; recev_ack = 1'b0; send_req = 1'b0; scan_mode = 2'd0;
        repeat (3) tick();
        check_zero_outputs("reset_state");
        reset = 1'b0;
        tick();
        checks++;
        if (state_out !== 3'd1 || recev_req !== 1'b1) begin
            errors++;
            $display("FAIL idle_exit: state=%0d req=%b required state=1 req=1", state_out, recev_req);
        end
    endtask

    task automatic test_mode(input int mode);
        plan_frame();
        scan_mode = 2'(mode);
        recv_frame(N, 0);
        send_frame(mode, 0, -1, 2'd0);
    endtask

    task automatic test_mode_latch;
        plan_frame();
        scan_mode = 2'd2;
        recv_frame(N, 0);
        send_frame(2, 0, 2, 2'd1);
    endtask

    task automatic test_reset_mid;
        random_frame();
        scan_mode = 2'd0;
        recv_frame(5, 0);
        reset = 1'b1;
        tick();
        check_zero_outputs("reset_mid_frame");
        reset = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 24'hAAAAAA;
        recv_frame(N, 0);
        send_frame(0, 0, -1, 2'd0);
    endtask

    task automatic test_slow_partner;
        int m;
        random_frame();
        m = int'($urandom_range(0, 3));
        scan_mode = 2'(m);
        recv_frame(N, 5);
        send_frame(m, 5, -1, 2'd0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            int m;
            random_frame();
            m = int'($urandom_range(0, 3));
            scan_mode = 2'(m);
            recv_frame(N, int'($urandom_range(0, 3)));
            send_frame(m, int'($urandom_range(0, 3)), int'($urandom_range(0, N - 2)), 2'($urandom));
        end
    endtask

`ifdef FRAMEBUF_CKSUM_EN
    task automatic test_cksum;
        logic [15:0] exp;
        for (int i = 0; i < N; i++) img[i] = 24'h030201;
        scan_mode = 2'd0;
        recv_frame(N, 0);
        send_frame(0, 0, -1, 2'd0);
        checks++;
        if (fd_ck !== 16'd48) begin
            errors++;
            $display("FAIL cksum_const: got %0d required 48", fd_ck);
        end
        random_frame();
        exp = '0;
        for (int i = 0; i < N; i++) exp = exp + 16'(img[i][7:0]) + 16'(img[i][15:8]) + 16'(img[i][23:16]);
        recv_frame(N, 1);
        send_frame(0, 1, -1, 2'd0);
        checks++;
        if (fd_ck !== exp) begin
            errors++;
            $display("FAIL cksum_random: got %0d required %0d", fd_ck, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mode(0);
        test_mode(1);
        test_mode(3);
        test_mode_latch();
        test_reset_mid();
        test_slow_partner();
        test_random();
`ifdef FRAMEBUF_CKSUM_EN
        test_cksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
